// File: rtl/rom_loader_pkg.sv
// Shared constants and types for the ROM download loader: region map, region
// indices and loader FSM states.
package rom_loader_pkg;

  localparam logic [24:0] CPU_BASE    = 25'h00000;
  localparam logic [24:0] CPU_SIZE    = 25'h08000;
  localparam logic [24:0] SND_BASE    = 25'h08000;
  localparam logic [24:0] SND_SIZE    = 25'h02000;
  localparam logic [24:0] TILE_BASE   = 25'h0A000;
  localparam logic [24:0] TILE_SIZE   = 25'h0C000;
  localparam logic [24:0] SPR_BASE    = 25'h16000;
  localparam logic [24:0] SPR_SIZE    = 25'h08000;
  localparam logic [24:0] TOTAL_BYTES = SPR_BASE + SPR_SIZE;

  typedef logic [1:0] region_t;

  localparam region_t REG_CPU  = 2'd0;
  localparam region_t REG_SND  = 2'd1;
  localparam region_t REG_TILE = 2'd2;
  localparam region_t REG_SPR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational linear-address decoder: image address -> {hit, region, local
// address}. Also used by the core's ROM-region arbitration.
module rom_region_decode
  import rom_loader_pkg::*;
(
  input  logic [24:0] addr_i,
  output logic        hit_o,
  output logic [1:0]  region_o,
  output logic [16:0] local_addr_o
);

  // Local offsets never exceed 17 bits, so subtracting in 17 bits is exact.
  always_comb begin
    hit_o        = 1'b1;
    region_o     = REG_CPU;
    local_addr_o = addr_i[16:0] - CPU_BASE[16:0];
    if (addr_i < CPU_BASE + CPU_SIZE) begin
      region_o     = REG_CPU;
      local_addr_o = addr_i[16:0] - CPU_BASE[16:0];
    end else if (addr_i < SND_BASE + SND_SIZE) begin
      region_o     = REG_SND;
      local_addr_o = addr_i[16:0] - SND_BASE[16:0];
    end else if (addr_i < TILE_BASE + TILE_SIZE) begin
      region_o     = REG_TILE;
      local_addr_o = addr_i[16:0] - TILE_BASE[16:0];
    end else if (addr_i < SPR_BASE + SPR_SIZE) begin
      region_o     = REG_SPR;
      local_addr_o = addr_i[16:0] - SPR_BASE[16:0];
    end else begin
      hit_o        = 1'b0;
      local_addr_o = 17'd0;
    end
  end

endmodule

// File: rtl/rom_region_loader.sv
// Routes the HPS download stream into the four ROM regions and qualifies the
// load. Define ROM_LOADER_CHECKSUM_EN to also require a 16-bit additive checksum.
module rom_region_loader
  import rom_loader_pkg::*;
#(
  parameter logic [7:0]  INDEX      = 8'd0,
  parameter logic [15:0] EXPECT_SUM = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [3:0]  rom_we,
  output logic        rom_ready,
  output logic        load_err
);

  localparam logic [17:0] TOTAL_CNT = TOTAL_BYTES[17:0];

  loader_state_t state_q;
  logic          dl_q;
  logic [17:0]   cnt_q;
  logic          ovf_q;
  logic [16:0]   rom_addr_q;
  logic [7:0]    rom_data_q;
  logic [3:0]    rom_we_q;
  logic          ready_q;
  logic          err_q;

  logic          dec_hit;
  logic [1:0]    dec_region;
  logic [16:0]   dec_local;

  rom_region_decode u_decode (
    .addr_i      (ioctl_addr),
    .hit_o       (dec_hit),
    .region_o    (dec_region),
    .local_addr_o(dec_local)
  );

  logic match_start;
  logic accept;
  logic dl_fall;
  logic sum_ok;
  logic pass;

  assign match_start = ioctl_download && (ioctl_index == INDEX);
  assign accept      = ioctl_wr && ioctl_download;
  assign dl_fall     = dl_q && !ioctl_download;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  assign sum_ok = (sum_q == EXPECT_SUM);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sum_q <= 16'd0;
    end else if ((state_q != LOAD) && match_start) begin
      sum_q <= 16'd0;
    end else if ((state_q == LOAD) && accept && dec_hit) begin
      sum_q <= sum_q + {8'h00, ioctl_dout};
    end
  end
`else
  logic [15:0] unused_expect_sum;

  assign unused_expect_sum = EXPECT_SUM;
  assign sum_ok            = 1'b1;
`endif

  assign pass = (cnt_q == TOTAL_CNT) && !ovf_q && sum_ok;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      cnt_q      <= 18'd0;
      ovf_q      <= 1'b0;
      rom_addr_q <= 17'd0;
      rom_data_q <= 8'd0;
      rom_we_q   <= 4'd0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dl_q     <= ioctl_download;
      rom_we_q <= 4'd0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (match_start) begin
            state_q <= LOAD;
            cnt_q   <= 18'd0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (dec_hit) begin
              rom_we_q   <= 4'b0001 << dec_region;
              rom_addr_q <= dec_local;
              rom_data_q <= ioctl_dout;
              cnt_q      <= cnt_q + 18'd1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (dl_fall) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          state_q <= pass ? DONE : ERR;
          ready_q <= pass;
          err_q   <= !pass;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_data  = rom_data_q;
  assign rom_we    = rom_we_q;
  assign rom_ready = ready_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_rom_region_loader.sv
// Directed bench for rom_region_loader with a cycle-stamped write scoreboard.
module tb_rom_region_loader;

  localparam logic [15:0] IMAGE_SUM = 16'h1000;
  localparam int          TOTAL     = 32'h1E000;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_we;
  logic        rom_ready;
  logic        load_err;

  rom_region_loader #(
    .INDEX     (8'd0),
    .EXPECT_SUM(IMAGE_SUM)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .rom_we        (rom_we),
    .rom_ready     (rom_ready),
    .load_err      (load_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [3:0]  we;
    logic [16:0] addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_exp_t;

  wr_exp_t     sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] cyc = 32'd0;

  always @(posedge clk_sys) cyc <= cyc + 32'd1;

  function automatic logic [3:0] model_we(input int a);
    if (a < 32'h08000) return 4'b0001;
    if (a < 32'h0A000) return 4'b0010;
    if (a < 32'h16000) return 4'b0100;
    if (a < 32'h1E000) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [16:0] model_loc(input int a);
    int b;
    if (a < 32'h08000)      b = 0;
    else if (a < 32'h0A000) b = 32'h08000;
    else if (a < 32'h16000) b = 32'h0A000;
    else                    b = 32'h16000;
    return 17'(a - b);
  endfunction

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write, including its cycle.
  always @(negedge clk_sys) begin
    if (!reset && rom_we !== 4'b0000) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $error("FAIL unexpected_we observed we=%b addr=%0h expected no write", rom_we, rom_addr);
      end else begin
        wr_exp_t e;
        e = sb.pop_front();
        assert ({rom_we, rom_addr, rom_data, cyc} === {e.we, e.addr, e.data, e.cyc})
        else begin
          n_fail++;
          $error("FAIL sb_write observed we=%b addr=%0h data=%0h cyc=%0d expected we=%b addr=%0h data=%0h cyc=%0d",
                 rom_we, rom_addr, rom_data, cyc, e.we, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic send(input int a, input logic [7:0] d, input bit exp_acc);
    wr_exp_t e;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (exp_acc && a < TOTAL) begin
      e.we   = model_we(a);
      e.addr = model_loc(a);
      e.data = d;
      e.cyc  = cyc + 32'd1;
      sb.push_back(e);
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic end_dl(input logic exp_rdy, input logic exp_err, input string tag);
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    @(posedge clk_sys); #1;
    check(32'(rom_ready), 32'd0, {tag, "_ready_edge"});
    check(32'(load_err), 32'd0, {tag, "_err_edge"});
    @(posedge clk_sys); #1;
    check(32'(rom_ready), 32'(exp_rdy), {tag, "_ready"});
    check(32'(load_err), 32'(exp_err), {tag, "_err"});
  endtask

  task automatic full_image(input int n, input int flip_at);
    for (int a = 0; a < n; a++) begin
      logic [7:0] d;
      d = 8'(a);
      if (a == flip_at) d = ~d;
      send(a, d, 1'b1);
      if (a == 32'h00100) begin
        check(32'(rom_we), 32'h1, "cpu_we");
      end
      if (a == 32'h0A000) begin
        check(32'(rom_we), 32'h4, "tile_first_we");
        check(32'(rom_addr), 32'h0, "tile_first_addr");
      end
      if (a == 32'h1DFFF) begin
        check(32'(rom_we), 32'h8, "spr_last_we");
        check(32'(rom_addr), 32'h7FFF, "spr_last_addr");
      end
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_sys);
    #1;
    check(32'(rom_we), 32'd0, "rst_we");
    check(32'(rom_addr), 32'd0, "rst_addr");
    check(32'(rom_data), 32'd0, "rst_data");
    check(32'(rom_ready), 32'd0, "rst_ready");
    check(32'(load_err), 32'd0, "rst_err");
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // Reset in the middle of a load.
    start_dl(8'd0);
    for (int a = 0; a < 32'h5000; a++) send(a, 8'(a), 1'b1);
    @(negedge clk_sys); #1;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    #1;
    check(32'(rom_we), 32'd0, "midrst_we");
    check(32'(rom_addr), 32'd0, "midrst_addr");
    check(32'(rom_data), 32'd0, "midrst_data");
    check(32'(rom_ready), 32'd0, "midrst_ready");
    check(32'(load_err), 32'd0, "midrst_err");
    @(posedge clk_sys); @(posedge clk_sys); #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // Full reload after reset.
    start_dl(8'd0);
    full_image(TOTAL, -1);
    end_dl(1'b1, 1'b0, "full");

    // Non-matching index leaves everything alone.
    start_dl(8'd1);
    for (int a = 0; a < 8; a++) begin
      send(a * 32'h3000, 8'hA5, 1'b0);
      check(32'(rom_we), 32'd0, "idx1_we");
    end
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check(32'(rom_ready), 32'd1, "idx1_ready");
    check(32'(load_err), 32'd0, "idx1_err");

    // Writes outside a download window are ignored.
    for (int a = 0; a < 4; a++) begin
      send(a, 8'h5A, 1'b0);
      check(32'(rom_we), 32'd0, "nodl_we");
    end

    // Short image.
    start_dl(8'd0);
    check(32'(rom_ready), 32'd0, "start_ready_drop");
    full_image(TOTAL - 1, -1);
    end_dl(1'b0, 1'b1, "short");

    // Full image plus one byte past the end.
    start_dl(8'd0);
    full_image(TOTAL, -1);
    send(TOTAL, 8'hAA, 1'b1);
    check(32'(rom_we), 32'd0, "extra_we");
    end_dl(1'b0, 1'b1, "extra");

`ifdef ROM_LOADER_CHECKSUM_EN
    start_dl(8'd0);
    full_image(TOTAL, -1);
    end_dl(1'b1, 1'b0, "sum_good");
    start_dl(8'd0);
    full_image(TOTAL, 32'h1234);
    end_dl(1'b0, 1'b1, "sum_bad");
`endif

    @(posedge clk_sys); #1;
    check(32'(sb.size()), 32'd0, "sb_drained");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
